// File: rtl/connect4_game_controller_if.sv
// Request/status bundle between the input controller, the grid logic and the turn sequencer.
// The timeout signal exists only when TURN_TIMEOUT_EN is defined.
interface connect4_game_controller_if #(
    parameter int unsigned ROWS = 6,
    parameter int unsigned COLS = 7
);
    logic                     move_req;
    logic [2:0]               column_select;
    logic                     column_full;
    logic [2*ROWS*COLS-1:0]   grid_flat;
    logic                     new_game;
    logic                     drop_en;
    logic [2:0]               drop_col;
    logic [1:0]               player;
    logic                     grid_clear;
    logic                     illegal_move;
    logic [5:0]               move_count;
    logic [1:0]               winner;
    logic                     game_over;
    logic                     draw;
    logic [2:0]               state;
`ifdef TURN_TIMEOUT_EN
    logic                     timeout;
`endif

    modport master (
        output move_req, column_select, column_full, grid_flat, new_game,
        input  drop_en, drop_col, player, grid_clear, illegal_move, move_count, winner,
               game_over, draw, state
`ifdef TURN_TIMEOUT_EN
        , input timeout
`endif
    );

    modport slave (
        input  move_req, column_select, column_full, grid_flat, new_game,
        output drop_en, drop_col, player, grid_clear, illegal_move, move_count, winner,
               game_over, draw, state
`ifdef TURN_TIMEOUT_EN
        , output timeout
`endif
    );
endinterface

// File: rtl/connect4_game_controller.sv
// Connect Four turn sequencer: gates drops, owns the turn, serially scans for four-in-a-row.
// Optional turn time limit enabled by defining TURN_TIMEOUT_EN.
module connect4_game_controller #(
    parameter int unsigned ROWS           = 6,
    parameter int unsigned COLS           = 7,
    parameter int unsigned SETTLE_CYCLES  = 2
`ifdef TURN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 251750000
`endif
) (
    input logic                       clk_25,
    input logic                       rst_n,
    connect4_game_controller_if.slave bus
);
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned SW    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned PW    = $clog2(2 * CELLS);

    localparam logic [2:0] WAIT_MOVE = 3'd0;
    localparam logic [2:0] SETTLE    = 3'd1;
    localparam logic [2:0] SCAN      = 3'd2;
    localparam logic [2:0] WIN       = 3'd3;
    localparam logic [2:0] DRAW      = 3'd4;
    localparam logic [1:0] P1        = 2'b01;

    logic [2:0]    state_q, state_d;
    logic [1:0]    player_q, player_d;
    logic [5:0]    count_q, count_d;
    logic [1:0]    winner_q, winner_d;
    logic [2:0]    drop_col_q, drop_col_d;
    logic          drop_en_q, drop_en_d;
    logic          clear_q, clear_d;
    logic          illegal_q, illegal_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
`ifdef TURN_TIMEOUT_EN
    logic [27:0]   to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;
`endif

    logic       hit;
    logic       accept;
    logic       scan_last;
    logic [5:0] count_inc;
    int         scan_r, scan_c;

    function automatic logic run_match(input logic [2*CELLS-1:0] grid, input logic [1:0] who,
                                       input int r, input int c, input int dr, input int dc);
        logic          ok;
        logic [PW-1:0] pos;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pos = PW'(2 * ((r + k * dr) * int'(COLS) + c + k * dc));
            ok  = ok & (grid[pos +: 2] == who);
        end
        return ok;
    endfunction

    // Only runs that stay inside the grid are ever evaluated.
    always_comb begin
        scan_r = int'(row_q);
        scan_c = int'(col_q);
        hit    = 1'b0;
        if (scan_c <= int'(COLS) - 4)
            hit = hit | run_match(bus.grid_flat, player_q, scan_r, scan_c, 0, 1);
        if (scan_r <= int'(ROWS) - 4)
            hit = hit | run_match(bus.grid_flat, player_q, scan_r, scan_c, 1, 0);
        if (scan_r <= int'(ROWS) - 4 && scan_c <= int'(COLS) - 4)
            hit = hit | run_match(bus.grid_flat, player_q, scan_r, scan_c, 1, 1);
        if (scan_r <= int'(ROWS) - 4 && scan_c >= 3)
            hit = hit | run_match(bus.grid_flat, player_q, scan_r, scan_c, 1, -1);
    end

    assign accept    = !bus.column_full && (32'(bus.column_select) < COLS);
    assign scan_last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
    assign count_inc = (32'(count_q) >= CELLS) ? count_q : count_q + 6'd1;

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        count_d    = count_q;
        winner_d   = winner_q;
        drop_col_d = drop_col_q;
        drop_en_d  = 1'b0;
        clear_d    = 1'b0;
        illegal_d  = 1'b0;
        settle_d   = settle_q;
        row_d      = row_q;
        col_d      = col_q;
`ifdef TURN_TIMEOUT_EN
        to_cnt_d   = '0;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            WAIT_MOVE: begin
                if (bus.move_req && accept) begin
                    drop_en_d  = 1'b1;
                    drop_col_d = bus.column_select;
                    settle_d   = '0;
                    state_d    = SETTLE;
                end else begin
                    illegal_d = bus.move_req;
`ifdef TURN_TIMEOUT_EN
                    if (to_cnt_q == 28'(TIMEOUT_CYCLES - 1)) begin
                        player_d  = player_q ^ 2'b11;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 28'd1;
                    end
`endif
                end
            end
            SETTLE: begin
                if (32'(settle_q) + 32'd1 >= SETTLE_CYCLES) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = SCAN;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            SCAN: begin
                if (hit) begin
                    winner_d = player_q;
                    count_d  = count_inc;
                    state_d  = WIN;
                end else if (scan_last) begin
                    count_d = count_inc;
                    if (32'(count_inc) == CELLS) begin
                        state_d = DRAW;
                    end else begin
                        player_d = player_q ^ 2'b11;
                        state_d  = WAIT_MOVE;
                    end
                end else if (col_q == CW'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            default: ;
        endcase

        // Restart wins over everything, including a same-cycle move request.
        if (bus.new_game) begin
            state_d    = WAIT_MOVE;
            player_d   = P1;
            count_d    = '0;
            winner_d   = '0;
            drop_col_d = '0;
            drop_en_d  = 1'b0;
            illegal_d  = 1'b0;
            clear_d    = 1'b1;
`ifdef TURN_TIMEOUT_EN
            to_cnt_d   = '0;
            timeout_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            state_q    <= WAIT_MOVE;
            player_q   <= P1;
            count_q    <= '0;
            winner_q   <= '0;
            drop_col_q <= '0;
            drop_en_q  <= 1'b0;
            clear_q    <= 1'b0;
            illegal_q  <= 1'b0;
            settle_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
`ifdef TURN_TIMEOUT_EN
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            player_q   <= player_d;
            count_q    <= count_d;
            winner_q   <= winner_d;
            drop_col_q <= drop_col_d;
            drop_en_q  <= drop_en_d;
            clear_q    <= clear_d;
            illegal_q  <= illegal_d;
            settle_q   <= settle_d;
            row_q      <= row_d;
            col_q      <= col_d;
`ifdef TURN_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.drop_en      = drop_en_q;
    assign bus.drop_col     = drop_col_q;
    assign bus.player       = player_q;
    assign bus.grid_clear   = clear_q;
    assign bus.illegal_move = illegal_q;
    assign bus.move_count   = count_q;
    assign bus.winner       = winner_q;
    assign bus.game_over    = (state_q == WIN) || (state_q == DRAW);
    assign bus.draw         = (state_q == DRAW);
    assign bus.state        = state_q;
`ifdef TURN_TIMEOUT_EN
    assign bus.timeout      = timeout_q;
`endif
endmodule

// File: tb/tb_connect4_game_controller.sv
// Bench for connect4_game_controller: acts as input controller and grid logic, and checks
// every move against a board-level model of the game rules.
module tb_connect4_game_controller;
    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int CELLS = ROWS * COLS;

    logic clk_25 = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_25 = ~clk_25;

    connect4_game_controller_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    connect4_game_controller #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk_25 (clk_25),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // Board model: 0 empty, 1 P1, 2 P2; row 0 is the top row.
    int g[ROWS][COLS];
    int m_player, m_count, m_winner;
    bit m_over, m_draw;
    int tests, fails;

    always_comb begin
        bus.grid_flat = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                bus.grid_flat[2*(r*COLS+c) +: 2] = 2'(g[r][c]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                g[r][c] = 0;
        m_player = 1;
        m_count  = 0;
        m_winner = 0;
        m_over   = 0;
        m_draw   = 0;
    endtask

    // First cell in row-major order that starts a four-run of player p, or -1.
    function automatic int first_hit(input int p);
        int dr[4];
        int dc[4];
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int idx = 0; idx < CELLS; idx++) begin
            for (int d = 0; d < 4; d++) begin
                int r0 = idx / COLS;
                int c0 = idx % COLS;
                int r3 = r0 + 3 * dr[d];
                int c3 = c0 + 3 * dc[d];
                bit all;
                if (r3 < 0 || r3 >= ROWS || c3 < 0 || c3 >= COLS) continue;
                all = 1;
                for (int k = 0; k < 4; k++)
                    if (g[r0 + k*dr[d]][c0 + k*dc[d]] != p) all = 0;
                if (all) return idx;
            end
        end
        return -1;
    endfunction

    function automatic int exp_state();
        return m_draw ? 4 : (m_over ? 3 : 0);
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_player"}, bus.player, m_player);
        check({tag, "_count"},  bus.move_count, m_count);
        check({tag, "_winner"}, bus.winner, m_winner);
        check({tag, "_over"},   bus.game_over, m_over || m_draw);
        check({tag, "_draw"},   bus.draw, m_draw);
        check({tag, "_state"},  bus.state, exp_state());
    endtask

    task automatic do_move(input int col, input bit apply, input bit force_full);
        bit full, legal;
        int hit, n, exp_n, row;
        full  = force_full || (apply && col < COLS && g[0][col] != 0);
        legal = (col < COLS) && !full;
        bus.move_req      = 1'b1;
        bus.column_select = 3'(col);
        bus.column_full   = full;
        @(negedge clk_25);
        bus.move_req    = 1'b0;
        bus.column_full = 1'b0;
        if (!legal) begin
            check("illegal_pulse", bus.illegal_move, 1);
            check("illegal_no_drop", bus.drop_en, 0);
            check("illegal_player", bus.player, m_player);
            check("illegal_state", bus.state, 0);
            @(negedge clk_25);
            check("illegal_once", bus.illegal_move, 0);
            return;
        end
        check("drop_en", bus.drop_en, 1);
        check("drop_col", bus.drop_col, col);
        check("no_illegal", bus.illegal_move, 0);
        if (apply) begin
            row = 0;
            for (int r = 0; r < ROWS; r++) if (g[r][col] == 0) row = r;
            g[row][col] = m_player;
        end
        @(negedge clk_25);
        check("drop_once", bus.drop_en, 0);
        @(negedge clk_25);
        check("scan_entry", bus.state, 2);
        hit   = first_hit(m_player);
        exp_n = (hit >= 0) ? hit + 1 : CELLS;
        n = 0;
        while (bus.state == 3'd2 && n < 200) begin
            if (n == 5 && exp_n > 8) begin
                bus.move_req      = 1'b1;
                bus.column_select = 3'($urandom_range(0, 6));
            end
            @(negedge clk_25);
            n++;
            if (n == 6 && exp_n > 8) begin
                bus.move_req = 1'b0;
                check("scan_ignores_req", {bus.illegal_move, bus.drop_en}, 0);
            end
        end
        check("scan_len", n, exp_n);
        m_count = (m_count < CELLS) ? m_count + 1 : m_count;
        if (hit >= 0) begin
            m_over   = 1;
            m_winner = m_player;
        end else if (m_count == CELLS) begin
            m_draw = 1;
        end else begin
            m_player = 3 - m_player;
        end
        check_status("after_move");
        check("drop_col_hold", bus.drop_col, col);
    endtask

    task automatic new_game(input bit with_req);
        bus.new_game = 1'b1;
        if (with_req) begin
            bus.move_req      = 1'b1;
            bus.column_select = 3'd2;
        end
        @(negedge clk_25);
        bus.new_game = 1'b0;
        bus.move_req = 1'b0;
        clear_model();
        check("ng_clear", bus.grid_clear, 1);
        check("ng_no_drop", bus.drop_en, 0);
        check("ng_no_illegal", bus.illegal_move, 0);
        check_status("ng");
        @(negedge clk_25);
        check("ng_clear_once", bus.grid_clear, 0);
        check("ng_req_dropped", bus.drop_en, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        tests = 0;
        fails = 0;
        clear_model();
        bus.move_req      = 1'b0;
        bus.column_select = 3'd0;
        bus.column_full   = 1'b0;
        bus.new_game      = 1'b0;

        repeat (3) @(negedge clk_25);
        check_status("reset");
        check("reset_drop_col", bus.drop_col, 0);
        check("reset_drop_en", bus.drop_en, 0);
        check("reset_clear", bus.grid_clear, 0);
        check("reset_illegal", bus.illegal_move, 0);
        rst_n = 1'b1;
        @(negedge clk_25);
        check_status("post_reset");

        // First move, no win.
        do_move(3, 1, 0);

        // Vertical P1 win in column 0; moves are then ignored.
        new_game(0);
        for (int i = 0; i < 7; i++) do_move((i % 2 == 0) ? 0 : 1, 1, 0);
        check("vert_winner", bus.winner, 1);
        bus.move_req      = 1'b1;
        bus.column_select = 3'd4;
        @(negedge clk_25);
        bus.move_req = 1'b0;
        check("win_no_drop", bus.drop_en, 0);
        check("win_no_illegal", bus.illegal_move, 0);
        check_status("win_hold");

        // Rejected requests.
        new_game(0);
        do_move(2, 1, 1);
        do_move(7, 1, 0);
        check_status("after_illegal");

        // Diagonal down-left P2 win from a loaded board.
        new_game(0);
        do_move(0, 0, 0);
        g[2][6] = 2; g[3][5] = 2; g[4][4] = 2; g[5][3] = 2;
        do_move(1, 0, 0);
        check("diag_winner", bus.winner, 2);

        // Cells that only line up if the scan wrapped around a row edge.
        new_game(0);
        g[0][4] = 1; g[0][5] = 1; g[0][6] = 1; g[1][0] = 1;
        do_move(2, 0, 0);
        check("wrap_no_win", bus.game_over, 0);

        // Full board without any four-in-a-row ends in a draw.
        new_game(0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                g[r][c] = ((((r + ((c == 3) ? 2 : 0)) / 2) % 2) == 0) ? 1 : 2;
        for (int i = 0; i < CELLS; i++) do_move($urandom_range(0, 6), 0, 0);
        check("draw_flag", bus.draw, 1);
        check("draw_winner", bus.winner, 0);
        check("draw_count", bus.move_count, CELLS);

        // Restart and reset in the middle of a scan.
        new_game(0);
        bus.move_req      = 1'b1;
        bus.column_select = 3'd5;
        @(negedge clk_25);
        bus.move_req = 1'b0;
        check("abort_drop", bus.drop_en, 1);
        repeat ($urandom_range(3, 30)) @(negedge clk_25);
        check("abort_in_scan", bus.state, 2);
        new_game(1);

        bus.move_req      = 1'b1;
        bus.column_select = 3'd1;
        @(negedge clk_25);
        bus.move_req = 1'b0;
        repeat ($urandom_range(4, 30)) @(negedge clk_25);
        rst_n = 1'b0;
        @(negedge clk_25);
        rst_n = 1'b1;
        clear_model();
        check_status("rst_mid_scan");
        check("rst_mid_scan_drop", bus.drop_en, 0);

        // Random games with gravity drops, occasional bad columns and full flags.
        for (int gm = 0; gm < 5; gm++) begin
            new_game(0);
            k = 0;
            while (!m_over && !m_draw && k < 80) begin
                do_move($urandom_range(0, 7), 1, $urandom_range(0, 9) == 0);
                k++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/connect4_game_controller.md
Name: connect4_game_controller

Overview:
Turn sequencer for the Connect Four datapath. It gates drop requests from the input controller into single `drop_en` pulses toward the grid logic and owns the player-turn register. After each drop it serially scans the grid for four-in-a-row and declares win or draw. It sits between the input controller and the grid logic, clocked on the 25.175 MHz VGA clock.

Parameters:
- ROWS, 6, grid rows; row 0 is the top row.
- COLS, 7, grid columns.
- SETTLE_CYCLES, 2, wait cycles after `drop_en` before scanning, so the grid has time to update.
- TIMEOUT_CYCLES, 251750000, turn time limit in clk_25 cycles (10 s). Used only when TURN_TIMEOUT_EN is defined.

Ports:
- clk_25  in  1  pixel clock; all logic on posedge.
- rst_n  in  1  reset: synchronous, active-low.
- move_req  in  1  one-cycle drop request pulse from the input controller.
- column_select  in  3  requested column.
- column_full  in  1  from grid logic: the column currently selected is full.
- grid_flat  in  2*ROWS*COLS  cell (r,c) at bits [2*(r*COLS+c)+:2]; 00 empty, 01 P1, 10 P2.
- new_game  in  1  one-cycle restart pulse.
- drop_en  out  1  one-cycle drop strobe to grid logic.
- drop_col  out  3  column for the drop, held stable from the `drop_en` cycle until the next accepted move.
- player  out  2  side to move (01/10).
- grid_clear  out  1  one-cycle grid clear strobe.
- illegal_move  out  1  one-cycle pulse on a rejected request.
- move_count  out  6  accepted moves this game.
- winner  out  2  00 none, else the winning code.
- game_over  out  1  high in WIN or DRAW.
- draw  out  1  high in DRAW.
- state  out  3  0 WAIT_MOVE, 1 SETTLE, 2 SCAN, 3 WIN, 4 DRAW.

Behaviour:

Reset and restart:
- Reset (rst_n=0 at a clock edge) gives: state WAIT_MOVE, player 01, move_count 0, winner 00, drop_col 0.
- All strobes (`drop_en`, `grid_clear`, `illegal_move`) are 0 after reset, as are `game_over` and `draw`. Reset mid-scan aborts the scan.
- `new_game` in any state has the same effect as reset, plus `grid_clear`=1 on the next cycle.
- `new_game` has priority over a simultaneous `move_req`; that `move_req` is dropped.

WAIT_MOVE:
- A move is accepted when `move_req`=1, `column_full`=0 and `column_select` < COLS.
- On acceptance: `drop_en`=1 and `drop_col`=`column_select` on the next cycle (1-cycle latency), then go to SETTLE.
- Any other `move_req` is rejected: `illegal_move`=1 on the next cycle, state and player unchanged.

SETTLE:
- Count SETTLE_CYCLES cycles, then go to SCAN.
- `move_req` is ignored here and throughout SCAN, WIN and DRAW; no `illegal_move` pulse.

SCAN:
- Index `idx` runs 0..ROWS*COLS-1, one cell per cycle; r = idx/COLS, c = idx%COLS.
- Each cycle, test the runs of 4 starting at (r,c) against the current `player`:
  - horizontal: (r,c..c+3), only if c ≤ COLS-4;
  - vertical: (r..r+3,c), only if r ≤ ROWS-4;
  - diagonal down-right: only if r ≤ ROWS-4 and c ≤ COLS-4;
  - diagonal down-left: only if r ≤ ROWS-4 and c ≥ 3.
- Runs that would fall off the grid are never evaluated.
- First hit: `winner`=`player`, go to WIN, `move_count`+1.
- Scan ends (idx=ROWS*COLS-1) with no hit: `move_count`+1.
  - If the new count equals ROWS*COLS: go to DRAW.
  - Otherwise: toggle player (01 to 10, 10 to 01) and return to WAIT_MOVE.
- Worst-case move-to-next-turn latency is 1+SETTLE_CYCLES+ROWS*COLS cycles (45 at defaults).

WIN and DRAW:
- `game_over`=1. DRAW also sets `draw`=1 with `winner` held at 00.
- `player` is frozen. Leave only on `new_game` or reset.

Other rules:
- `move_count` saturates at ROWS*COLS.
- `player` never takes the values 00 or 11.

Optional Feature:

TURN_TIMEOUT_EN
- Defined:
  - A 28-bit counter runs in WAIT_MOVE and is cleared on entry to WAIT_MOVE and on each accepted move.
  - When it reaches TIMEOUT_CYCLES-1, the turn is forfeited: `player` toggles, `move_count` is unchanged, and a `timeout` output (1 bit, port added only under the macro) pulses for one cycle.
  - A move accepted in the same cycle as the timeout wins over the timeout.
- Undefined: no counter, no `timeout` port; a turn waits indefinitely.

Test Plan:
1. Reset, then `move_req` with `column_select`=3 and `column_full`=0 → `drop_en`=1 and `drop_col`=3 exactly 1 cycle later; `state`=SCAN after 2 more cycles; `player`=10 and `move_count`=1 after 42 scan cycles.
2. P1 plays col 0 four times, P2 plays col 1 three times (bench grid model) → after the 7th move `winner`=01, `game_over`=1, `move_count`=7; a further `move_req` gives no `drop_en` and no `illegal_move`.
3. `column_full`=1 with `move_req`, then `column_select`=7 with `move_req` → two `illegal_move` pulses, no `drop_en`, `player` still 01.
4. Diagonal down-left P2 win on cells (2,6),(3,5),(4,4),(5,3) → `winner`=10. A P1 row at (0,4..6) plus (1,0) → no win declared.
5. 42 alternating moves forming a full grid with no four-in-a-row → `draw`=1, `winner`=00, `move_count`=42.
6. `new_game` asserted mid-SCAN together with `move_req` → `grid_clear` pulse, `state`=0, `player`=01, `move_count`=0, no `drop_en`. With TURN_TIMEOUT_EN and TIMEOUT_CYCLES=100: idle 100 cycles → `timeout` pulse and `player`=10.
